// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C configuration sequencer and its table ROMs.
package i2c_cfg_pkg;

   // Table entry layout: {op[1:0], reg[7:0], val[7:0]}
   localparam int unsigned ENTRY_W = 18;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_DELAY = 2'b01;
   localparam logic [1:0] OP_END   = 2'b10;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StFetch    = 3'd1,
      StIssue    = 3'd2,
      StWaitDone = 3'd3,
      StDelay    = 3'd4,
      StDone     = 3'd5,
      StError    = 3'd6
   } state_t;

endpackage

// File: rtl/hdmi_config_rom.sv
// ADV7513 register-init table; combinational lookup, out-of-range reads return END.
module hdmi_config_rom
   import i2c_cfg_pkg::*;
#(
   parameter int unsigned ENTRY_COUNT = 31,
   parameter int unsigned IDX_W       = 8
) (
   input  logic [IDX_W-1:0]   index,
   output logic [ENTRY_W-1:0] entry
);

   logic [15:0] wr;
   logic        valid;

   // Decode index into a {reg, val} write, falling back to END past the table.
   always_comb begin
      wr    = 16'h0000;
      valid = 1'b1;
      case (32'(index))
         0:  wr = 16'h9803;
         1:  wr = 16'h0100;
         2:  wr = 16'h0218;
         3:  wr = 16'h0300;
         4:  wr = 16'h1470;
         5:  wr = 16'h1520;
         6:  wr = 16'h1630;
         7:  wr = 16'h1846;
         8:  wr = 16'h4080;
         9:  wr = 16'h4110;
         10: wr = 16'h49a8;
         11: wr = 16'h5510;
         12: wr = 16'h5608;
         13: wr = 16'h96f6;
         14: wr = 16'h7307;
         15: wr = 16'h761f;
         16: wr = 16'h9803;
         17: wr = 16'h9902;
         18: wr = 16'h9ae0;
         19: wr = 16'h9c30;
         20: wr = 16'h9d61;
         21: wr = 16'ha2a4;
         22: wr = 16'ha3a4;
         23: wr = 16'ha504;
         24: wr = 16'hab40;
         25: wr = 16'haf16;
         26: wr = 16'hba60;
         27: wr = 16'hd1ff;
         28: wr = 16'hde10;
         29: wr = 16'he460;
         30: wr = 16'hfa7d;
         default: valid = 1'b0;
      endcase
      if (32'(index) >= ENTRY_COUNT) valid = 1'b0;
      entry = valid ? {OP_WRITE, wr} : {OP_END, 16'h0000};
   end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks a configuration table and issues each WRITE entry as a 3-byte I2C write,
// with DELAY entries, bounded NACK retry, early END, abort and status reporting.
module i2c_config_sequencer
   import i2c_cfg_pkg::*;
#(
   parameter int unsigned ENTRY_COUNT = 31,
   parameter int unsigned IDX_W       = 8,
   parameter logic [6:0]  DEV_ADDR    = 7'h39,
   parameter int unsigned MAX_RETRIES = 3,
   parameter int unsigned DELAY_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic               i2c_busy,
   input  logic               i2c_done,
   input  logic               i2c_nack,
   output logic [6:0]         address,
   output logic [7:0]         data_0,
   output logic [7:0]         data_1,
   output logic               i2c_start,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [IDX_W-1:0]   cur_index,
   output logic [IDX_W-1:0]   rom_index,
   input  logic [ENTRY_W-1:0] rom_entry
);

   localparam int unsigned CNT_W = DELAY_W + 8;
   localparam int unsigned RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRY_COUNT - 1);

   state_t             state_q, state_d;
   logic               start_q;
   logic               start_rise;
   logic [7:0]         data0_q, data0_d;
   logic [7:0]         data1_q, data1_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [RTY_W-1:0]   retry_q, retry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               i2c_start_q, i2c_start_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic               advance;
   logic               in_run;
   logic [23:0]        delay_raw;
   logic [CNT_W-1:0]   delay_load;

   // Delay entries count in units of 256 clk.
   assign delay_raw  = {rom_entry[15:0], 8'h00};
   assign delay_load = CNT_W'(delay_raw);

   assign start_rise = start & ~start_q;
   assign in_run     = (state_q != StIdle) && (state_q != StDone) && (state_q != StError);

   assign address   = DEV_ADDR;
   assign data_0    = data0_q;
   assign data_1    = data1_q;
   assign i2c_start = i2c_start_q;
   assign busy      = in_run;
   assign done      = done_q;
   assign error     = error_q;
   assign cur_index = idx_q;
   assign rom_index = idx_q;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         start_q     <= 1'b0;
         data0_q     <= 8'h00;
         data1_q     <= 8'h00;
         idx_q       <= '0;
         retry_q     <= '0;
         cnt_q       <= '0;
         i2c_start_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= start;
         data0_q     <= data0_d;
         data1_q     <= data1_d;
         idx_q       <= idx_d;
         retry_q     <= retry_d;
         cnt_q       <= cnt_d;
         i2c_start_q <= i2c_start_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   // Next-state logic: table walk, transfer handshake, retry and abort.
   always_comb begin
      state_d     = state_q;
      data0_d     = data0_q;
      data1_d     = data1_q;
      idx_d       = idx_q;
      retry_d     = retry_q;
      cnt_d       = cnt_q;
      i2c_start_d = 1'b0;
      done_d      = done_q;
      error_d     = error_q;
      advance     = 1'b0;

      case (state_q)
         StIdle, StDone, StError: begin
            if (start_rise) begin
               done_d  = 1'b0;
               error_d = 1'b0;
               idx_d   = '0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            case (rom_entry[17:16])
               OP_WRITE: begin
                  data0_d = rom_entry[15:8];
                  data1_d = rom_entry[7:0];
                  retry_d = '0;
                  state_d = StIssue;
               end
               OP_DELAY: begin
                  cnt_d   = delay_load;
                  state_d = StDelay;
               end
               // END and the reserved opcode both terminate the table.
               default: begin
                  done_d  = 1'b1;
                  state_d = StDone;
               end
            endcase
         end
         StIssue: begin
            if (!i2c_busy) begin
               i2c_start_d = 1'b1;
               state_d     = StWaitDone;
            end
         end
         // i2c_busy is deliberately ignored here so a late busy rise cannot re-trigger.
         StWaitDone: begin
            if (i2c_done) begin
               if (!i2c_nack) begin
                  advance = 1'b1;
               end else if (retry_q < RTY_W'(MAX_RETRIES)) begin
                  retry_d = retry_q + RTY_W'(1);
                  state_d = StIssue;
               end else begin
                  error_d = 1'b1;
                  state_d = StError;
               end
            end
         end
         StDelay: begin
            if (cnt_q == '0) advance = 1'b1;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = StIdle;
      endcase

      if (advance) begin
         if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = StDone;
         end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = StFetch;
         end
      end

      // Abort wins over everything, including a simultaneous i2c_done.
      if (in_run && abort) begin
         idx_d       = idx_q;
         i2c_start_d = 1'b0;
         error_d     = 1'b1;
         state_d     = StError;
      end
   end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Randomized self-checking bench with a transaction-level reference model.
module tb_i2c_config_sequencer;

   localparam int unsigned ENTRY_COUNT = 31;
   localparam int          MAXR        = 3;
   localparam logic [6:0]  DEV_ADDR    = 7'h39;

   logic        clk, rst_n, start, abort, i2c_busy, i2c_done, i2c_nack;
   logic [6:0]  address;
   logic [7:0]  data_0, data_1;
   logic        i2c_start, busy, done, error;
   logic [7:0]  cur_index, rom_index;
   logic [17:0] rom_entry, rom_out;

   // Bench-side table state
   bit          use_rom;
   logic [17:0] tbl [256];
   logic [15:0] adv_tbl [31] = '{
      16'h9803, 16'h0100, 16'h0218, 16'h0300, 16'h1470, 16'h1520, 16'h1630, 16'h1846,
      16'h4080, 16'h4110, 16'h49a8, 16'h5510, 16'h5608, 16'h96f6, 16'h7307, 16'h761f,
      16'h9803, 16'h9902, 16'h9ae0, 16'h9c30, 16'h9d61, 16'ha2a4, 16'ha3a4, 16'ha504,
      16'hab40, 16'haf16, 16'hba60, 16'hd1ff, 16'hde10, 16'he460, 16'hfa7d};
   int          nack_plan [256];
   int          nack_left [256];

   // Master model state
   logic        m_busy, m_nack, force_busy;
   int          m_cnt;
   bit          glitch_en, lat_rand;

   // Scoreboard
   logic [15:0] exp_q [$];
   bit          exp_err;
   int          exp_idx, exp_total;
   int          pulses, cnt_1520;
   logic [15:0] first_data, last_data;
   int          cyc, last_idone_cyc, done_rise_cyc;
   logic        prev_start, prev_busy, prev_done;
   int          n_checks = 0;
   int          n_fail = 0;

   assign i2c_busy  = m_busy | force_busy;
   assign rom_entry = use_rom ? rom_out : tbl[rom_index];

   hdmi_config_rom #(.ENTRY_COUNT(ENTRY_COUNT), .IDX_W(8)) u_rom (
      .index (rom_index),
      .entry (rom_out)
   );

   i2c_config_sequencer #(
      .ENTRY_COUNT (ENTRY_COUNT),
      .IDX_W       (8),
      .DEV_ADDR    (DEV_ADDR),
      .MAX_RETRIES (MAXR),
      .DELAY_W     (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .i2c_busy  (i2c_busy),
      .i2c_done  (i2c_done),
      .i2c_nack  (i2c_nack),
      .address   (address),
      .data_0    (data_0),
      .data_1    (data_1),
      .i2c_start (i2c_start),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .cur_index (cur_index),
      .rom_index (rom_index),
      .rom_entry (rom_entry)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting, required event never seen (t=%0t)", name, $time);
   endtask

   function automatic logic [17:0] model_entry(input int i);
      return use_rom ? {2'b00, adv_tbl[i]} : tbl[i];
   endfunction

   // Expected transfer list and final status from the table and NACK plan.
   function automatic void build_expected();
      logic [17:0] e;
      bit          stop;
      int          n;
      exp_q.delete();
      exp_err = 1'b0;
      exp_idx = ENTRY_COUNT - 1;
      stop    = 1'b0;
      for (int i = 0; i < ENTRY_COUNT && !stop; i++) begin
         e = model_entry(i);
         if (e[17:16] == 2'b00) begin
            n = nack_plan[i];
            for (int a = 0; a <= MAXR && a <= n; a++) exp_q.push_back(e[15:0]);
            if (n > MAXR) begin
               exp_err = 1'b1;
               exp_idx = i;
               stop    = 1'b1;
            end
         end else if (e[17:16] != 2'b01) begin
            exp_idx = i;
            stop    = 1'b1;
         end
      end
      exp_total = exp_q.size();
      for (int i = 0; i < 256; i++) nack_left[i] = nack_plan[i];
   endfunction

   // I2C master model: busy while a transfer is in flight, done/nack after a latency.
   initial begin
      m_busy = 1'b0; m_nack = 1'b0; m_cnt = 0; i2c_done = 1'b0; i2c_nack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            m_busy = 1'b0; m_cnt = 0; i2c_done = 1'b0; i2c_nack = 1'b0;
            continue;
         end
         i2c_done = 1'b0;
         i2c_nack = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               i2c_done = 1'b1;
               i2c_nack = m_nack;
               m_busy   = 1'b0;
            end else if (glitch_en) begin
               m_busy = 1'($urandom_range(0, 1));
            end
         end else if (i2c_start) begin
            m_cnt  = lat_rand ? int'($urandom_range(2, 15)) : 10;
            m_busy = 1'b1;
            if (nack_left[cur_index] > 0) begin
               m_nack = 1'b1;
               nack_left[cur_index]--;
            end else begin
               m_nack = 1'b0;
            end
         end
      end
   end

   // Per-cycle compare against the scoreboard and output invariants.
   initial begin : compare
      logic [15:0] e;
      cyc = 0; prev_start = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_start = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
            continue;
         end
         if (i2c_done) last_idone_cyc = cyc;
         if (done && !prev_done) done_rise_cyc = cyc;
         check("address", {25'b0, address}, {25'b0, DEV_ADDR});
         check("done_and_error", {31'b0, done & error}, 32'd0);
         check("busy_with_status", {31'b0, busy & (done | error)}, 32'd0);
         if (i2c_start) begin
            check("start_width", {31'b0, prev_start}, 32'd0);
            check("start_while_busy", {31'b0, prev_busy}, 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_start: actual data %02h/%02h, required no transfer",
                        data_0, data_1);
            end else begin
               e = exp_q.pop_front();
               check("xfer_data", {16'b0, data_0, data_1}, {16'b0, e});
            end
            if (pulses == 0) first_data = {data_0, data_1};
            last_data = {data_0, data_1};
            if ({data_0, data_1} == 16'h1520) cnt_1520++;
            pulses++;
         end
         prev_start = i2c_start;
         prev_busy  = i2c_busy;
         prev_done  = done;
      end
   end

   // One full sequence: start edge, optional busy hold, run to completion, check status.
   task automatic run_seq(input bit measure, input int hold);
      int k;
      build_expected();
      pulses = 0; cnt_1520 = 0; first_data = '0; last_data = '0;
      force_busy = (hold > 0);
      @(posedge clk);
      #1;
      start = 1'b1;
      if (measure) begin
         k = 0;
         do begin
            @(posedge clk);
            #1;
            k++;
            start = 1'b0;
         end while (!i2c_start && k < 10);
         check("start_latency", k, 3);
      end else begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1;
         check("held_no_start", pulses, 0);
         force_busy = 1'b0;
      end
      k = 0;
      repeat (2) @(negedge clk);
      while ((busy || m_cnt != 0) && k < 30000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 30000) timeout("run_complete");
      check("xfers_outstanding", exp_q.size(), 0);
      check("final_done", {31'b0, done}, {31'b0, ~exp_err});
      check("final_error", {31'b0, error}, {31'b0, exp_err});
      check("final_busy", {31'b0, busy}, 32'd0);
      check("final_index", {24'b0, cur_index}, exp_idx);
      repeat (20) @(negedge clk);
      check("no_late_xfers", pulses, exp_total);
   endtask

   task automatic clear_plan();
      for (int i = 0; i < 256; i++) nack_plan[i] = 0;
   endtask

   initial begin
      int k, gap;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; force_busy = 1'b0;
      glitch_en = 1'b0; lat_rand = 1'b0; use_rom = 1'b1;
      for (int i = 0; i < 256; i++) tbl[i] = {2'b10, 16'h0000};
      clear_plan();
      build_expected();

      repeat (3) @(posedge clk);
      #1;
      check("rst_i2c_start", {31'b0, i2c_start}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_error", {31'b0, error}, 32'd0);
      check("rst_data", {16'b0, data_0, data_1}, 32'd0);
      check("rst_index", {24'b0, cur_index}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Nominal ADV7513 run with fixed 10-clk master latency
      run_seq(1'b1, 0);
      check("nom_pulses", pulses, 31);
      check("nom_first", {16'b0, first_data}, 32'h9803);
      check("nom_last", {16'b0, last_data}, 32'hfa7d);

      // Abort outside a run has no effect
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      @(posedge clk); #1;
      check("idle_abort_done", {31'b0, done}, 32'd1);
      check("idle_abort_error", {31'b0, error}, 32'd0);

      // Two NACKs on entry 5 recover; four exhaust the retries
      clear_plan(); nack_plan[5] = 2;
      run_seq(1'b0, 0);
      check("nack2_attempts", cnt_1520, 3);
      check("nack2_done", {31'b0, done}, 32'd1);
      clear_plan(); nack_plan[5] = 4;
      run_seq(1'b0, 0);
      check("nack4_attempts", cnt_1520, 4);
      check("nack4_error", {31'b0, error}, 32'd1);
      check("nack4_index", {24'b0, cur_index}, 32'd5);
      clear_plan();

      // Delay and early END
      use_rom = 1'b0;
      tbl[0] = {2'b00, 16'h4110};
      tbl[1] = {2'b01, 16'h0002};
      tbl[2] = {2'b10, 16'h0000};
      tbl[3] = {2'b00, 16'haabb};
      run_seq(1'b0, 0);
      gap = done_rise_cyc - last_idone_cyc;
      check("delay_gap_in_range", {31'b0, (gap >= 512 && gap <= 520)}, 32'd1);
      check("delay_pulses", pulses, 1);
      check("delay_last", {16'b0, last_data}, 32'h4110);
      use_rom = 1'b1;

      // Busy held at ISSUE, busy glitching during the transfer
      glitch_en = 1'b1;
      run_seq(1'b0, 20);
      glitch_en = 1'b0;

      // Abort mid-transfer at entry 10, then restart
      build_expected();
      pulses = 0;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      k = 0;
      while (!(cur_index == 8'd10 && m_cnt > 3) && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 5000) timeout("abort_wait_entry10");
      @(posedge clk); #1;
      check("abort_pulses_before", pulses, 11);
      abort = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_error", {31'b0, error}, 32'd1);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_i2c_start", {31'b0, i2c_start}, 32'd0);
      check("abort_index", {24'b0, cur_index}, 32'd10);
      k = 0;
      while (m_cnt != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      repeat (20) @(negedge clk);
      check("abort_late_done_ignored", {31'b0, error}, 32'd1);
      check("abort_still_idle", {31'b0, busy}, 32'd0);
      check("abort_no_new_pulses", pulses, 11);
      run_seq(1'b0, 0);

      // Asynchronous reset at entry 7
      build_expected();
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      k = 0;
      while (cur_index != 8'd7 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 5000) timeout("reset_wait_entry7");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_i2c_start", {31'b0, i2c_start}, 32'd0);
      check("arst_busy", {31'b0, busy}, 32'd0);
      check("arst_done", {31'b0, done}, 32'd0);
      check("arst_error", {31'b0, error}, 32'd0);
      check("arst_data", {16'b0, data_0, data_1}, 32'd0);
      check("arst_index", {24'b0, cur_index}, 32'd0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      run_seq(1'b0, 0);

      // Randomized tables, NACK plans, latencies and busy glitches
      lat_rand = 1'b1;
      for (int it = 0; it < 8; it++) begin
         use_rom   = (it % 2 == 1);
         glitch_en = 1'($urandom_range(0, 1));
         for (int i = 0; i < 256; i++) tbl[i] = {2'b10, 16'h0000};
         for (int i = 0; i < ENTRY_COUNT; i++) begin
            k = int'($urandom_range(0, 99));
            if (k < 80)      tbl[i] = {2'b00, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
            else if (k < 94) tbl[i] = {2'b01, 8'h00, 8'($urandom_range(0, 1))};
            else if (k < 97) tbl[i] = {2'b10, 16'h0000};
            else             tbl[i] = {2'b11, 16'($urandom)};
            nack_plan[i] = ($urandom_range(0, 99) < 12) ? int'($urandom_range(1, 4)) : 0;
         end
         run_seq(1'b0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_config_sequencer.md
Name: i2c_config_sequencer

Overview:
Generalised successor to the fixed HDMI register-init queue. Walks a parametrised table of configuration entries and issues each as a 3-byte I2C write (device address, register, data) to the existing I2C master. Adds delay entries, NACK retry with bounded attempts, early table termination, abort, completion/error status and progress reporting. Sits between system control (power-up or hot-plug restart) and the I2C master; the table lives in a separate ROM sub-module so other I2C peripherals can reuse the sequencer.

Parameters:
ENTRY_COUNT, 31, number of table entries (1..256)
IDX_W, 8, index width; must satisfy 2^IDX_W >= ENTRY_COUNT
DEV_ADDR, 7'h39, 7-bit I2C device address driven on address
MAX_RETRIES, 3, extra attempts per write after a NACK (0 = no retry)
DELAY_W, 16, width of the delay counter; delay entries count in units of 256 clk

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  rising-edge request to run the table from entry 0; ignored while busy
abort  in  1  level; forces return to IDLE, sets error
i2c_busy  in  1  master busy level
i2c_done  in  1  one-cycle strobe: transfer finished
i2c_nack  in  1  valid with i2c_done; 1 = slave NACK
address  out  7  constant DEV_ADDR
data_0  out  8  register address of current write
data_1  out  8  register data of current write
i2c_start  out  1  one-cycle transfer request
busy  out  1  sequence in progress
done  out  1  sticky; last sequence completed cleanly
error  out  1  sticky; last sequence failed or was aborted
cur_index  out  IDX_W  index of the entry being processed
rom_index  out  IDX_W  table address to ROM sub-module
rom_entry  in  18  {op[1:0], reg[7:0], val[7:0]} from ROM, combinational

Behaviour:
- Reset (async, rst_n=0): state IDLE; i2c_start, busy, done, error = 0; data_0, data_1 = 0; cur_index = 0; retry and delay counters = 0.
- Start detection: registered edge detector on start; a rising edge in IDLE, DONE or ERROR clears done/error, sets cur_index=0, goes to FETCH. Edges in any other state are ignored.
- Opcodes: 2'b00 WRITE, 2'b01 DELAY (delay = {reg,val} x 256 clk, truncated to DELAY_W+8 bits), 2'b10 END, 2'b11 reserved (treated as END).
- States:
  - IDLE/DONE/ERROR: wait for start.
  - FETCH: one cycle; latch rom_entry. WRITE: load data_0/data_1, retry count = 0, go ISSUE. DELAY: load counter, go DELAY. END: go DONE.
  - ISSUE: if i2c_busy=0, pulse i2c_start for exactly one cycle and go WAIT_DONE; else hold.
  - WAIT_DONE: ignore i2c_busy and wait for i2c_done. This makes the i2c_busy double-shot impossible.
    - nack=0: advance.
    - nack=1 and retries < MAX_RETRIES: increment retries, go ISSUE.
    - Otherwise set error and go ERROR.
  - DELAY: decrement each clk; at 0, advance. A delay value of 0 advances after one cycle.
  - Advance: if cur_index == ENTRY_COUNT-1, go DONE; else cur_index+1, go FETCH. There is no wrap.
- DONE sets done=1. busy=1 in every state except IDLE, DONE and ERROR.
- abort=1 in any busy state: next cycle go ERROR, error=1, i2c_start=0. A transfer already in flight in the master is not cancelled; its later i2c_done is ignored. abort in IDLE/DONE/ERROR has no effect. abort has priority over a simultaneous i2c_done.
- If i2c_done and start arrive in the same cycle, start is ignored (busy).
- Latency: the first i2c_start occurs 3 clk after the start rising edge, provided i2c_busy=0 (edge detect, FETCH, ISSUE).
- rom_index = cur_index; the ROM is combinational, so data is valid in FETCH.

Decomposition:
- Shared package i2c_cfg_pkg: opcode constants OP_WRITE, OP_DELAY, OP_END; entry width 18; state encoding constants.
- Sub-module hdmi_config_rom: parameter ENTRY_COUNT, input index, output 18-bit entry.
  - Holds the ADV7513 table: 31 WRITE entries, e.g. 0x98<-0x03, 0x01<-0x00, 0x02<-0x18, ..., 0xfa<-0x7d.
  - Out-of-range index returns OP_END.

Test Plan:
- Nominal run: ROM of 31 writes, master model returns done/ack 10 clk after each start -> exactly 31 i2c_start pulses; first with data_0=0x98, data_1=0x03, last with 0xfa/0x7d; done=1, error=0, busy=0.
- NACK retry: NACK on the first 2 attempts of entry 5 (0x15/0x20), MAX_RETRIES=3 -> 3 pulses carry 0x15/0x20, the sequence completes, done=1. With 4 NACKs -> error=1, cur_index=5, no further i2c_start.
- Delay and END: table {WRITE 0x41/0x10, DELAY 0x0002, END, WRITE 0xaa/0xbb} -> 512 clk gap after the first write completes, done=1, 0xaa never issued.
- Busy hold and double-shot: i2c_busy held high for 20 clk at ISSUE -> i2c_start withheld until busy low. i2c_busy glitching during WAIT_DONE -> still exactly one pulse per entry.
- Abort and restart: abort at entry 10 mid-transfer -> ERROR next clk, later i2c_done ignored. A new start edge -> error cleared, run restarts at entry 0 and completes.
- Async reset mid-run: rst_n low at entry 7 asynchronously -> all outputs reach reset values without a clock edge. After release, start runs from entry 0.
